// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, opcode fields and the
// two-word instruction classifier used by fetch.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT_HI   = 2'd0,
    BOOT_LO   = 2'd1,
    RUN       = 2'd2,
    FETCH_IMM = 2'd3
  } fetch_state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam logic [4:0] OPC_NOP  = 5'h00;
  localparam logic [4:0] OPC_LDM  = 5'h0C;
  localparam logic [4:0] OPC_IADD = 5'h0D;
  localparam logic [4:0] OPC_LDD  = 5'h0E;
  localparam logic [4:0] OPC_STD  = 5'h0F;

  localparam logic [15:0] NOP_ENC = 16'h0000;

  // LDM/IADD/LDD/STD carry a 16-bit immediate in the following word.
  function automatic logic is_two_word(input logic [15:0] instr);
    logic [4:0] opc;
    opc = instr[OPC_MSB:OPC_LSB];
    return (opc == OPC_LDM) || (opc == OPC_IADD) ||
           (opc == OPC_LDD) || (opc == OPC_STD);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, immediate, return PC and valid.
// Bubble clears the instruction fields but keeps the last return PC.
module if_id_reg #(
  parameter int          PC_W      = 32,
  parameter int          INSTR_W   = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [INSTR_W-1:0] imm_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] imm_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] imm_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q <= NOP_INSTR;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      imm_q   <= imm_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign imm_o   = imm_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, boot-vector load, two-word assembly and
// redirect/stall/flush handling in front of the IF/ID register.
//
// state     | meaning
// BOOT_HI   | reading high half of boot vector
// BOOT_LO   | reading low half, then jump to vector
// RUN       | fetching an opcode word
// FETCH_IMM | fetching the immediate of a two-word instruction
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] BOOT_ADDR = '0,
  parameter logic [15:0]     NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               pc_load_mem,
  input  logic [PC_W-1:0]    pc_mem_value,
  output logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] immediate,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] pc_hi_q, pc_hi_d;
  logic [INSTR_W-1:0] op_hold_q, op_hold_d;

  logic               ifid_load;
  logic               ifid_bubble;
  logic [INSTR_W-1:0] ifid_instr;
  logic [INSTR_W-1:0] ifid_imm;

  logic [PC_W-1:0]    pc_inc;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;

  assign pc_inc      = pc_q + PC_W'(1);
  assign redirect    = pc_load_mem | branch_taken;
  assign redirect_pc = pc_load_mem ? pc_mem_value : branch_target;
  assign imem_addr   = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_hi_d     = pc_hi_q;
    op_hold_d   = op_hold_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_data;
    ifid_imm    = '0;

    case (state_q)
      // Boot ignores stall, flush and redirects so the vector is always taken.
      BOOT_HI: begin
        pc_hi_d = imem_data;
        pc_d    = BOOT_ADDR + PC_W'(1);
        state_d = BOOT_LO;
      end
      BOOT_LO: begin
        pc_d    = PC_W'({pc_hi_q, imem_data});
        state_d = RUN;
      end
      default: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          state_d     = RUN;
          op_hold_d   = '0;
          ifid_bubble = 1'b1;
        end else if (flush) begin
          // With stall also high the squash happens but the PC must not move.
          ifid_bubble = 1'b1;
          if (!stall) begin
            pc_d    = pc_inc;
            state_d = RUN;
          end
        end else if (stall) begin
          state_d = state_q;
        end else if (state_q == RUN) begin
          pc_d = pc_inc;
          if (is_two_word(imem_data)) begin
            op_hold_d   = imem_data;
            state_d     = FETCH_IMM;
            ifid_bubble = 1'b1;
          end else begin
            ifid_load = 1'b1;
          end
        end else begin
          pc_d       = pc_inc;
          state_d    = RUN;
          ifid_load  = 1'b1;
          ifid_instr = op_hold_q;
          ifid_imm   = imem_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT_HI;
      pc_q      <= BOOT_ADDR;
      pc_hi_q   <= '0;
      op_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_hi_q   <= pc_hi_d;
      op_hold_q <= op_hold_d;
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .instr_i  (ifid_instr),
    .imm_i    (ifid_imm),
    .pc_i     (pc_inc),
    .instr_o  (instruction),
    .imm_o    (immediate),
    .pc_o     (pc_out),
    .valid_o  (instr_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected post-edge
// address and IF/ID contents; a monitor pops and compares on each falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pc_load_mem;
  logic [31:0] pc_mem_value;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic [31:0] pc_out;
  logic        instr_valid;

  logic [15:0] mem [0:511];

  typedef struct {
    logic [31:0] a;
    logic [15:0] i;
    logic [15:0] m;
    logic [31:0] p;
    logic        v;
    string       n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 16'h0000;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_load_mem   (pc_load_mem),
    .pc_mem_value  (pc_mem_value),
    .instruction   (instruction),
    .immediate     (immediate),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (imem_addr !== e.a || instruction !== e.i || immediate !== e.m ||
            pc_out !== e.p || instr_valid !== e.v) begin
          errors++;
          $display("FAIL %s: got addr=%h ins=%h imm=%h pc_out=%h valid=%b, want addr=%h ins=%h imm=%h pc_out=%h valid=%b",
                   e.n, imem_addr, instruction, immediate, pc_out, instr_valid,
                   e.a, e.i, e.m, e.p, e.v);
        end
      end
    end
  end

  task automatic set_in(input logic rst, input logic stl, input logic fl,
                        input logic br, input logic [31:0] bt,
                        input logic pl, input logic [31:0] pv);
    reset         = rst;
    stall         = stl;
    flush         = fl;
    branch_taken  = br;
    branch_target = bt;
    pc_load_mem   = pl;
    pc_mem_value  = pv;
  endtask

  task automatic cyc(input logic [31:0] a, input logic [15:0] i, input logic [15:0] m,
                     input logic [31:0] p, input logic v, input string n);
    exp_t e;
    e.a = a; e.i = i; e.m = m; e.p = p; e.v = v; e.n = n;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 16'h0000;
    mem[0]     = 16'h0000;  mem[1]     = 16'h0020;
    mem[9'h20] = 16'h1111;  mem[9'h21] = 16'h2222;
    mem[9'h22] = 16'h6000;  mem[9'h23] = 16'hBEEF;  // LDM + imm
    mem[9'h24] = 16'h3333;
    mem[9'h25] = 16'h6800;  mem[9'h26] = 16'h1234;  // IADD + imm
    mem[9'h3F] = 16'h1357;  mem[9'h40] = 16'h8888;
    mem[9'h41] = 16'h9999;  mem[9'h42] = 16'hAAAA;
    mem[9'h43] = 16'h7000;  mem[9'h44] = 16'h5678;  // LDD + imm
    mem[9'h45] = 16'hBBBB;
    mem[9'h100] = 16'h4444; mem[9'h101] = 16'h5555;

    set_in(1, 0, 0, 0, 0, 0, 0);
    cyc(32'h0, 16'h0, 16'h0, 32'h0, 0, "reset0");
    cyc(32'h0, 16'h0, 16'h0, 32'h0, 0, "reset1");

    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h1, 16'h0, 16'h0, 32'h0, 0, "boot_hi");
    set_in(0, 1, 0, 1, 32'h300, 0, 0);
    cyc(32'h20, 16'h0, 16'h0, 32'h0, 0, "boot_lo_ignores_stall_branch");

    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h21, 16'h1111, 16'h0, 32'h21, 1, "seq0");
    cyc(32'h22, 16'h2222, 16'h0, 32'h22, 1, "seq1");
    cyc(32'h23, 16'h0000, 16'h0, 32'h22, 0, "two_word_bubble");
    cyc(32'h24, 16'h6000, 16'hBEEF, 32'h24, 1, "two_word_ldm");
    cyc(32'h25, 16'h3333, 16'h0, 32'h25, 1, "after_two_word");
    cyc(32'h26, 16'h0000, 16'h0, 32'h25, 0, "iadd_bubble");

    set_in(0, 0, 0, 1, 32'h100, 0, 0);
    cyc(32'h100, 16'h0000, 16'h0, 32'h25, 0, "branch_in_fetch_imm");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h101, 16'h4444, 16'h0, 32'h101, 1, "op_hold_dropped");

    set_in(0, 0, 0, 1, 32'h200, 1, 32'h3F);
    cyc(32'h3F, 16'h0000, 16'h0, 32'h101, 0, "mem_beats_branch");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h40, 16'h1357, 16'h0, 32'h40, 1, "at_0x40");

    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      cyc(32'h40, 16'h1357, 16'h0, 32'h40, 1, "stall_hold");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h41, 16'h8888, 16'h0, 32'h41, 1, "stall_resume");

    set_in(0, 1, 1, 0, 0, 0, 0);
    cyc(32'h41, 16'h0000, 16'h0, 32'h41, 0, "stall_flush");
    set_in(0, 0, 1, 0, 0, 0, 0);
    cyc(32'h42, 16'h0000, 16'h0, 32'h41, 0, "flush_run");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h43, 16'hAAAA, 16'h0, 32'h43, 1, "after_flush");
    cyc(32'h44, 16'h0000, 16'h0, 32'h43, 0, "ldd_bubble");
    set_in(0, 0, 1, 0, 0, 0, 0);
    cyc(32'h45, 16'h0000, 16'h0, 32'h43, 0, "flush_fetch_imm");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h46, 16'hBBBB, 16'h0, 32'h46, 1, "after_imm_abort");

    set_in(0, 0, 0, 1, 32'h43, 0, 0);
    cyc(32'h43, 16'h0000, 16'h0, 32'h46, 0, "branch_0x43");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h44, 16'h0000, 16'h0, 32'h46, 0, "enter_fetch_imm");
    set_in(1, 0, 0, 0, 0, 0, 0);
    cyc(32'h0, 16'h0000, 16'h0, 32'h0, 0, "reset_in_fetch_imm");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h1, 16'h0000, 16'h0, 32'h0, 0, "reboot_hi");
    cyc(32'h20, 16'h0000, 16'h0, 32'h0, 0, "reboot_lo");
    cyc(32'h21, 16'h1111, 16'h0, 32'h21, 1, "reboot_run");

    set_in(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    cyc(32'hFFFF_FFFF, 16'h0000, 16'h0, 32'h21, 0, "branch_top");
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc(32'h0, 16'h0000, 16'h0, 32'h0, 1, "pc_wrap");
    cyc(32'h1, 16'h0000, 16'h0, 32'h1, 1, "after_wrap");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
